// File: rtl/matrix_data_writer.sv
// Writes a row-major element stream into RAM as a rows x cols matrix, either
// row-major or transposed, behind a single registered write port.
module matrix_data_writer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11,
  parameter int DIM_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [DIM_W-1:0]         rows,
  input  logic [DIM_W-1:0]         cols,
  input  logic                     col_major,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     ram_wr_en,
  output logic [ADDR_W-1:0]        ram_wr_addr,
  output logic [DATA_W-1:0]        ram_wr_data,
  input  logic                     ram_wr_ready,
  output logic [ADDR_W-1:0]        write_count,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err,
  output logic                     overflow_err
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE, ERROR} state_t;
  state_t st, st_nxt;

  logic [ADDR_W-1:0] base_q, total_q, acc_cnt, cm_off, beat_addr;
  logic [DIM_W-1:0]  rows_q, cols_q, r_idx, c_idx;
  logic              cm_q, cfg_ok, can_start, accept, wr_fire, last_wr;

  assign cfg_ok    = (rows != '0) && (cols != '0);
  assign can_start = start && !abort && (st != WRITE);
  assign accept    = in_valid && in_ready;
  assign wr_fire   = ram_wr_en && ram_wr_ready;
  assign last_wr   = (st == WRITE) && wr_fire && ((write_count + 1'b1) == total_q);

  // Row-major offset is just the beat index; transposed uses c*rows + r.
  assign cm_off    = ADDR_W'(c_idx) * ADDR_W'(rows_q) + ADDR_W'(r_idx);
  assign beat_addr = base_q + (cm_q ? cm_off : acc_cnt);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;

  always_comb begin
    st_nxt = st;
    if (abort) st_nxt = IDLE;
    else case (st)
      WRITE:   if (last_wr) st_nxt = DONE;
      default: if (start)   st_nxt = cfg_ok ? WRITE : ERROR;
    endcase
  end

  always_comb begin
    busy     = (st == WRITE);
    done     = (st == DONE);
    in_ready = (st == WRITE) && (acc_cnt < total_q) && (!ram_wr_en || ram_wr_ready);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ram_wr_en    <= 1'b0;
      ram_wr_addr  <= '0;
      ram_wr_data  <= '0;
      write_count  <= '0;
      acc_cnt      <= '0;
      cfg_err      <= 1'b0;
      overflow_err <= 1'b0;
      base_q       <= '0;
      total_q      <= '0;
      rows_q       <= '0;
      cols_q       <= '0;
      r_idx        <= '0;
      c_idx        <= '0;
      cm_q         <= 1'b0;
    end else begin
      if (wr_fire) write_count <= write_count + 1'b1;

      // Output register: load on accept, hold until the RAM takes it.
      if (abort)
        ram_wr_en <= 1'b0;
      else if (accept) begin
        ram_wr_en   <= 1'b1;
        ram_wr_addr <= beat_addr;
        ram_wr_data <= in_data;
        acc_cnt     <= acc_cnt + 1'b1;
        if (c_idx == cols_q - 1'b1) begin
          c_idx <= '0;
          r_idx <= r_idx + 1'b1;
        end else
          c_idx <= c_idx + 1'b1;
      end else if (ram_wr_ready)
        ram_wr_en <= 1'b0;

      if (st == DONE && in_valid) overflow_err <= 1'b1;

      if (can_start) begin
        cfg_err <= !cfg_ok;
        if (cfg_ok) begin
          base_q       <= base_addr;
          rows_q       <= rows;
          cols_q       <= cols;
          cm_q         <= col_major;
          total_q      <= ADDR_W'(rows) * ADDR_W'(cols);
          write_count  <= '0;
          acc_cnt      <= '0;
          r_idx        <= '0;
          c_idx        <= '0;
          overflow_err <= 1'b0;
        end
      end
    end

endmodule

// File: tb/tb_matrix_data_writer.sv
// Bench for matrix_data_writer: directed and randomized transfers checked
// against a placement model computed from row/column indices.
module tb_matrix_data_writer;
  localparam int DW = 32, AW = 11, DMW = 5;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, col_major = 1'b0;
  logic in_valid = 1'b0, ram_wr_ready = 1'b1;
  logic [AW-1:0] base_addr = '0;
  logic [DMW-1:0] rows = '0, cols = '0;
  logic signed [DW-1:0] in_data = '0;
  logic in_ready, ram_wr_en, busy, done, cfg_err, overflow_err;
  logic [AW-1:0] ram_wr_addr, write_count;
  logic [DW-1:0] ram_wr_data;

  int total = 0, bad = 0;
  int unsigned cyc_n = 0;
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  int unsigned   wc_q[$];
  logic [DW-1:0] sent_d[$];
  int cur_base = 0;

  matrix_data_writer #(.DATA_W(DW), .ADDR_W(AW), .DIM_W(DMW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .rows(rows), .cols(cols), .col_major(col_major),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_wr_ready(ram_wr_ready), .write_count(write_count), .busy(busy),
    .done(done), .cfg_err(cfg_err), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  // Record every RAM handshake that will complete on the coming rising edge.
  always @(negedge clk) begin
    cyc_n <= cyc_n + 1;
    if (rst_n && ram_wr_en && ram_wr_ready) begin
      wa_q.push_back(ram_wr_addr);
      wd_q.push_back(ram_wr_data);
      wc_q.push_back(cyc_n);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int b, input int r, input int c, input bit cm);
    wa_q.delete(); wd_q.delete(); wc_q.delete(); sent_d.delete();
    cur_base = b;
    base_addr = AW'(b); rows = DMW'(r); cols = DMW'(c); col_major = cm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready low 3 cycles once the first write appears
  task automatic run_stream(input int n, input int mode, input bit seqd);
    int k, cyc, stall;
    bit stalled, acc;
    logic [DW-1:0] cur;
    k = 0; cyc = 0; stall = 0; stalled = 0; cur = $urandom;
    while (!(k == n && wa_q.size() >= n) && cyc < 400) begin
      if (mode == 2 && !stalled && ram_wr_en) begin stalled = 1; stall = 3; end
      if (stall > 0)      ram_wr_ready = 1'b0;
      else if (mode == 1) ram_wr_ready = ($urandom_range(0, 2) != 0);
      else                ram_wr_ready = 1'b1;
      in_valid = (k < n);
      in_data  = seqd ? DW'(k + 1) : cur;
      @(negedge clk);
      if (stall > 0) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_addr_hold", ram_wr_addr, AW'(cur_base));
        chk("stall_data_hold", ram_wr_data, sent_d[0]);
        stall--;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin sent_d.push_back(in_data); k++; cur = $urandom; end
      cyc++;
    end
    in_valid = 1'b0;
    ram_wr_ready = 1'b1;
    chk("stream_in_time", cyc < 400, 1);
  endtask

  task automatic check_list(input int b, input int r, input int c, input bit cm, input int n);
    chk("write_total", wa_q.size(), n);
    for (int k = 0; k < n && k < wa_q.size(); k++) begin
      int rr, cc, a;
      rr = k / c; cc = k % c;
      a  = cm ? (b + cc * r + rr) : (b + rr * c + cc);
      chk($sformatf("addr[%0d]", k), wa_q[k], a % (1 << AW));
      chk($sformatf("data[%0d]", k), wd_q[k], sent_d[k]);
    end
  endtask

  initial begin
    int r, c, b;
    bit cm;
    repeat (2) @(posedge clk); #1;
    chk("rst_wr_en", ram_wr_en, 0);
    chk("rst_wr_addr", ram_wr_addr, 0);
    chk("rst_wr_data", ram_wr_data, 0);
    chk("rst_write_count", write_count, 0);
    chk("rst_status", {busy, done, cfg_err, overflow_err, in_ready}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // row-major, back-to-back
    do_start(16, 2, 3, 0);
    run_stream(6, 0, 1);
    check_list(16, 2, 3, 0, 6);
    for (int i = 1; i < wc_q.size(); i++) chk("back_to_back", wc_q[i] - wc_q[0], i);
    chk("done_after_rm", done, 1);
    chk("busy_after_rm", busy, 0);
    chk("wc_after_rm", write_count, 6);

    // stray beat while done
    in_valid = 1'b1; in_data = 99;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("overflow_set", overflow_err, 1);
    chk("overflow_no_write", wa_q.size(), 6);
    chk("overflow_still_done", done, 1);

    // transposed
    do_start(16, 2, 3, 1);
    chk("overflow_cleared", overflow_err, 0);
    run_stream(6, 0, 1);
    check_list(16, 2, 3, 1, 6);

    // backpressure on first write
    do_start(16, 2, 3, 0);
    run_stream(6, 2, 1);
    check_list(16, 2, 3, 0, 6);
    chk("wc_after_stall", write_count, 6);

    // address wrap
    do_start(12'h7FE, 1, 4, 0);
    run_stream(4, 0, 0);
    check_list(12'h7FE, 1, 4, 0, 4);

    // zero dimension
    do_start(32, 0, 3, 0);
    chk("cfg_err_set", cfg_err, 1);
    chk("cfg_err_busy", busy, 0);
    in_valid = 1'b1; in_data = 7;
    repeat (3) @(posedge clk); #1;
    in_valid = 1'b0;
    chk("cfg_err_no_write", wa_q.size(), 0);
    do_start(32, 2, 2, 1);
    chk("cfg_err_cleared", cfg_err, 0);
    chk("busy_after_good", busy, 1);
    run_stream(4, 1, 0);
    check_list(32, 2, 2, 1, 4);

    // randomized configurations with random backpressure
    repeat (5) begin
      r = $urandom_range(1, 6); c = $urandom_range(1, 6);
      b = $urandom_range(0, 2047); cm = 1'($urandom);
      do_start(b, r, c, cm);
      run_stream(r * c, 1, 0);
      check_list(b, r, c, cm, r * c);
      chk("rnd_done", done, 1);
      chk("rnd_write_count", write_count, r * c);
    end

    // abort after two beats
    do_start(256, 2, 3, 0);
    run_stream(2, 0, 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_wc", write_count, 2);
    chk("abort_wr_en", ram_wr_en, 0);

    // abort with pending write beats a simultaneous start
    do_start(256, 2, 3, 0);
    ram_wr_ready = 1'b0; in_valid = 1'b1; in_data = 5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pending_write", ram_wr_en, 1);
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    chk("abort_prio_busy", busy, 0);
    chk("abort_drop_wr", ram_wr_en, 0);
    ram_wr_ready = 1'b1;

    // reset mid-transfer
    do_start(64, 2, 3, 0);
    ram_wr_ready = 1'b0; in_valid = 1'b1; in_data = 11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_reset_pending", ram_wr_en, 1);
    rst_n = 1'b0;
    #2;
    chk("reset_wr_en", ram_wr_en, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; ram_wr_ready = 1'b1; in_valid = 1'b1;
    repeat (4) @(posedge clk); #1;
    in_valid = 1'b0;
    chk("reset_no_write", wa_q.size(), 0);
    chk("reset_wc", write_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/matrix_data_writer.md
MATRIX_DATA_WRITER -- requirements
Module: matrix_data_writer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the element width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 11, meaning the RAM address and count width.
REQ-003 The block SHALL have parameter DIM_W, default 5, meaning the rows/cols field width.
REQ-004 The block SHALL have port clk, input, 1, clock; all logic rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 The block SHALL have port start, input, 1, one-cycle pulse that latches the config and arms a transfer.
REQ-007 The block SHALL have port abort, input, 1, synchronous cancel of the current transfer.
REQ-008 The block SHALL have port base_addr, input, ADDR_W, first RAM address of the matrix.
REQ-009 The block SHALL have ports rows and cols, input, DIM_W each, matrix dimensions.
REQ-010 The block SHALL have port col_major, input, 1, meaning 1 stores column-major (transposed) and 0 stores row-major.
REQ-011 The block SHALL have ports in_data (DATA_W, signed), in_valid (1) and in_ready (output, 1), forming the element stream, always row-major order.
REQ-012 The block SHALL have ports ram_wr_en (output, 1), ram_wr_addr (output, ADDR_W), ram_wr_data (output, DATA_W) and ram_wr_ready (input, 1), forming the RAM write port.
REQ-013 The block SHALL have ports write_count (ADDR_W), busy, done, cfg_err and overflow_err, all outputs, as status.

Function
REQ-014 The FSM SHALL have states IDLE, WRITE, DONE and ERROR.
REQ-015 In IDLE, a start with rows!=0 and cols!=0 SHALL latch base_addr/rows/cols/col_major, clear write_count and overflow_err, and enter WRITE.
REQ-016 In IDLE, a start with rows==0 or cols==0 SHALL enter ERROR and set cfg_err.
REQ-017 A start while in WRITE SHALL be ignored.
REQ-018 A start while in DONE or ERROR SHALL behave as in IDLE; cfg_err SHALL clear on any accepted start.
REQ-019 in_ready SHALL be state==WRITE && accepted_count<total && (!ram_wr_en || ram_wr_ready), where accepted_count counts stream beats accepted this transfer (ADDR_W bits).
REQ-020 A beat SHALL be accepted on in_valid && in_ready.
REQ-021 An accepted beat SHALL cause ram_wr_en=1 with its data and address in the next cycle (1-cycle latency).
REQ-022 The output register SHALL hold ram_wr_en/addr/data stable until ram_wr_ready=1.
REQ-023 Beat k (0-based, row r=k/cols, column c=k%cols) SHALL be written to base+r*cols+c when col_major=0, and to base+c*rows+r when col_major=1.
REQ-024 Address arithmetic SHALL be modulo 2^ADDR_W, wrapping silently.
REQ-025 total=rows*cols SHALL be computed in ADDR_W bits; the caller guarantees no overflow.
REQ-026 write_count SHALL increment on each cycle with ram_wr_en && ram_wr_ready.
REQ-027 When the write completing count==total is accepted by the RAM, the FSM SHALL enter DONE, with ram_wr_en=0 in that next cycle unless another beat is pending.
REQ-028 busy SHALL be 1 exactly in WRITE.
REQ-029 done SHALL be 1 exactly in DONE.
REQ-030 in_valid=1 while in DONE SHALL set overflow_err, which is sticky until the next accepted start or reset.
REQ-031 The beat presented with in_valid=1 in DONE SHALL not be written.
REQ-032 abort in any state SHALL go to IDLE next cycle, drop any pending ram_wr_en, and keep write_count.
REQ-033 abort SHALL take priority over a simultaneous start.
REQ-034 A simultaneous ram_wr_ready and new accept SHALL sustain 1 write/cycle throughput.

Reset
REQ-035 rst_n low SHALL force state IDLE; ram_wr_en, ram_wr_addr, ram_wr_data, write_count, accepted_count, busy, done, cfg_err and overflow_err to 0; and in_ready to 0.
REQ-036 Reset mid-transfer SHALL discard the pending write with no further RAM writes until a new start.

Verification
REQ-037 base=0x010, rows=2, cols=3, col_major=0, 6 back-to-back beats 1..6, ram_wr_ready=1 -> addresses 0x010..0x015 with data 1..6 on consecutive cycles, then done=1 and write_count=6.
REQ-038 The same config with col_major=1 -> data 1..6 written to addresses 0x010,0x012,0x014,0x011,0x013,0x015.
REQ-039 ram_wr_ready=0 for 3 cycles after the first write -> addr/data held for 3 cycles, in_ready=0 meanwhile, no beat lost, and 6 writes total.
REQ-040 base=0x7FE, rows=1, cols=4 -> addresses 0x7FE, 0x7FF, 0x000, 0x001.
REQ-041 rows=0 on start -> cfg_err=1, busy=0, no writes; then a valid start -> cfg_err=0.
REQ-042 After done, in_valid=1 with data 99 -> overflow_err=1 and no RAM write; abort after 2 of 6 beats -> IDLE, write_count=2, ram_wr_en=0.
